ram_block_engine: RTL and testbench

- Bus-master companion to the three-port working RAM (read ports A and B, write port C).
- Executes block operations over an address range without CPU involvement:
  - FILL: write a stepped pattern.
  - COPY: read port A, write port C.
  - COMPARE: read ports A and B, count mismatches.
- Sits between the CPU control unit (start/op/operands) and the RAM port pins. It is the initiator side of the RAM's port protocol.

---
 rtl/ram_block_engine.sv | 139 +++++++++++++
 tb/tb_ram_block_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_engine.sv
// Block FILL/COPY/COMPARE engine driving the three-port working RAM
// (read ports A/B, write port C); one word per clock, addresses wrap.
module ram_block_engine #(
  parameter int AWIDTH = 8,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [AWIDTH:0]   length,
  input  logic [WIDTH-1:0]  fill_data,
  input  logic [WIDTH-1:0]  fill_step,
  output logic [AWIDTH-1:0] port_a_address,
  input  logic [WIDTH-1:0]  port_a_out,
  output logic [AWIDTH-1:0] port_b_address,
  input  logic [WIDTH-1:0]  port_b_out,
  output logic [AWIDTH-1:0] port_c_address,
  output logic [WIDTH-1:0]  port_c_data,
  output logic              port_c_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH:0]   mismatch_count,
  output logic [AWIDTH-1:0] first_mismatch
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  localparam logic [1:0]      OP_FILL = 2'b00;
  localparam logic [1:0]      OP_COPY = 2'b01;
  localparam logic [1:0]      OP_CMP  = 2'b10;
  localparam logic [1:0]      OP_RSV  = 2'b11;
  localparam logic [AWIDTH:0] ONE     = 1;

  state_t              state, state_n;
  logic [1:0]          op_q;
  logic [AWIDTH:0]     cnt_q, mcnt_q;
  logic [AWIDTH-1:0]   a_q, b_q, c_q, idx_q, first_q;
  logic [WIDTH-1:0]    data_q, step_q;
  logic                we_q, pend_q, err_q;
  logic [AWIDTH-1:0]   gap;
  logic                overlap, reject, accept, last;

  // A COPY whose destination lies ahead of the source inside the range
  // would read words it already overwrote.
  assign gap     = dst_addr - src_addr;
  assign overlap = (op == OP_COPY) && (dst_addr != src_addr) && ({1'b0, gap} < length);
  assign reject  = (op == OP_RSV) || overlap;
  assign accept  = (state == IDLE) && start;
  assign last    = (cnt_q == ONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (reject || length == '0) ? FINISH : RUN;
      RUN:     if (last)  state_n = (op_q == OP_FILL) ? FINISH : DRAIN;
      DRAIN:   state_n = FINISH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_FILL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      step_q  <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      mcnt_q  <= '0;
      first_q <= '1;
    end else begin
      pend_q <= (state == RUN) && (op_q != OP_FILL);
      if (accept) begin
        op_q    <= op;
        cnt_q   <= length;
        a_q     <= src_addr;
        b_q     <= dst_addr;
        c_q     <= dst_addr;
        idx_q   <= '0;
        data_q  <= fill_data;
        step_q  <= fill_step;
        err_q   <= reject;
        mcnt_q  <= '0;
        first_q <= '1;
        we_q    <= (op == OP_FILL) && (length != '0);
      end
      if (state == RUN) begin
        cnt_q <= cnt_q - ONE;
        if (!last) begin
          a_q <= a_q + 1'b1;
          b_q <= b_q + 1'b1;
        end
        if (op_q == OP_FILL) begin
          data_q <= data_q - step_q;
          we_q   <= !last;
          if (!last) c_q <= c_q + 1'b1;
        end else if (op_q == OP_COPY) begin
          // Write trails the read by one cycle; DRAIN carries the final word.
          we_q <= 1'b1;
          if (we_q) c_q <= c_q + 1'b1;
        end
      end
      if (state == DRAIN) we_q <= 1'b0;
      if (pend_q && op_q == OP_CMP) begin
        idx_q <= idx_q + 1'b1;
        if (port_a_out != port_b_out) begin
          mcnt_q <= mcnt_q + ONE;
          if (first_q == '1) first_q <= idx_q;
        end
      end
    end
  end

  assign port_a_address = a_q;
  assign port_b_address = b_q;
  assign port_c_address = c_q;
  // COPY forwards read data straight to the write port in the same cycle.
  assign port_c_data    = (we_q && op_q == OP_COPY) ? port_a_out : data_q;
  assign port_c_we      = we_q;
  assign busy           = (state != IDLE);
  assign done           = (state == FINISH);
  assign err            = err_q;
  assign mismatch_count = mcnt_q;
  assign first_mismatch = first_q;

endmodule

// File: tb/tb_ram_block_engine.sv
// Directed bench for ram_block_engine with a behavioural 3-port RAM model.
module tb_ram_block_engine;

  logic       clk, rst_n, start;
  logic [1:0] op;
  logic [7:0] src_addr, dst_addr, fill_data, fill_step;
  logic [8:0] length;
  logic [7:0] port_a_address, port_a_out, port_b_address, port_b_out;
  logic [7:0] port_c_address, port_c_data;
  logic       port_c_we, busy, done, err;
  logic [8:0] mismatch_count;
  logic [7:0] first_mismatch;

  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  ram_block_engine #(.AWIDTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .fill_step(fill_step),
    .port_a_address(port_a_address), .port_a_out(port_a_out),
    .port_b_address(port_b_address), .port_b_out(port_b_out),
    .port_c_address(port_c_address), .port_c_data(port_c_data),
    .port_c_we(port_c_we), .busy(busy), .done(done), .err(err),
    .mismatch_count(mismatch_count), .first_mismatch(first_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data valid one clock after the address, write on the edge.
  always @(posedge clk) begin
    port_a_out <= mem[port_a_address];
    port_b_out <= mem[port_b_address];
    if (port_c_we) mem[port_c_address] <= port_c_data;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] src, dst;
    logic [8:0] len;
    logic [7:0] fd, fs;
    logic       exp_err;
    int         exp_busy, exp_we, exp_fw;
    int         exp_mc, exp_first;
  } vec_t;

  // Issue one command and profile busy/we/done per cycle until done.
  task automatic run_cmd(input vec_t v, input int poke,
                         output int bc, output int wc, output int dc,
                         output int fw, output int lw);
    bc = 0; wc = 0; dc = 0; fw = -1; lw = -1;
    @(negedge clk);
    op = v.op; src_addr = v.src; dst_addr = v.dst; length = v.len;
    fill_data = v.fd; fill_step = v.fs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == poke) begin start = 1'b1; op = 2'b11; end
      else start = 1'b0;
      if (busy) bc++;
      if (port_c_we) begin wc++; if (fw < 0) fw = cyc; lw = cyc; end
      if (done) begin dc++; break; end
    end
    start = 1'b0;
    if (dc == 0) begin
      checks++; failures++;
      $display("FAIL timeout waiting for done actual=0 required=1");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
  endtask

  vec_t tbl [7];
  vec_t v;
  int bc, wc, dc, fw, lw, bad;

  initial begin
    for (int n = 0; n < 256; n++) mem[n] = 8'h00;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_addr = 8'h00; dst_addr = 8'h00;
    length = 9'd0; fill_data = 8'h00; fill_step = 8'h00;

    tbl[0] = '{2'b00, 8'h00, 8'h00, 9'd256, 8'hFF, 8'h01, 1'b0, 257, 256, 1, 0, 8'hFF};
    tbl[1] = '{2'b01, 8'h10, 8'h80, 9'd16,  8'h00, 8'h00, 1'b0, 18,  16,  2, 0, 8'hFF};
    tbl[2] = '{2'b10, 8'h10, 8'h80, 9'd16,  8'h00, 8'h00, 1'b0, 18,  0,  -1, 0, 8'hFF};
    tbl[3] = '{2'b00, 8'h00, 8'hFE, 9'd4,   8'h40, 8'h02, 1'b0, 5,   4,   1, 0, 8'hFF};
    tbl[4] = '{2'b11, 8'h00, 8'h30, 9'd4,   8'h00, 8'h00, 1'b1, 1,   0,  -1, 0, 8'hFF};
    tbl[5] = '{2'b01, 8'h00, 8'h02, 9'd4,   8'h00, 8'h00, 1'b1, 1,   0,  -1, 0, 8'hFF};
    tbl[6] = '{2'b00, 8'h00, 8'h40, 9'd0,   8'h11, 8'h01, 1'b0, 1,   0,  -1, 0, 8'hFF};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", port_c_we, 0);
    check("rst_addr_a", port_a_address, 0);
    check("rst_addr_c", port_c_address, 0);
    check("rst_data_c", port_c_data, 0);
    check("rst_mc", mismatch_count, 0);
    check("rst_first", first_mismatch, 8'hFF);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i], -1, bc, wc, dc, fw, lw);
      check($sformatf("v%0d_busy", i), bc, tbl[i].exp_busy);
      check($sformatf("v%0d_we", i), wc, tbl[i].exp_we);
      check($sformatf("v%0d_first_we", i), fw, tbl[i].exp_fw);
      if (wc > 0) check($sformatf("v%0d_we_contig", i), lw - fw + 1, wc);
      check($sformatf("v%0d_done", i), dc, 1);
      check($sformatf("v%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("v%0d_mc", i), mismatch_count, tbl[i].exp_mc);
      check($sformatf("v%0d_first", i), first_mismatch, tbl[i].exp_first);
      if (i == 0) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== 8'(8'hFF - n)) bad++;
        check("fill_ram_bad_words", bad, 0);
      end
      if (i == 1) begin
        bad = 0;
        for (int n = 0; n < 16; n++) if (mem[8'h80 + n] !== 8'(8'hEF - n)) bad++;
        check("copy_ram_bad_words", bad, 0);
        check("copy_ram_90", mem[8'h90], 8'h6F);
      end
      if (i == 3) begin
        check("wrap_fe", mem[8'hFE], 8'h40);
        check("wrap_ff", mem[8'hFF], 8'h3E);
        check("wrap_00", mem[8'h00], 8'h3C);
        check("wrap_01", mem[8'h01], 8'h3A);
        check("wrap_02", mem[8'h02], 8'hFD);
      end
      if (i >= 4) check($sformatf("v%0d_ram_30", i), mem[8'h30], 8'hCF);
    end

    // COMPARE with one planted difference at offset 5.
    mem[8'h85] = 8'h00;
    v = '{2'b10, 8'h10, 8'h80, 9'd16, 8'h00, 8'h00, 1'b0, 18, 0, -1, 1, 8'h05};
    run_cmd(v, -1, bc, wc, dc, fw, lw);
    check("cmp1_mc", mismatch_count, 1);
    check("cmp1_first", first_mismatch, 8'h05);
    check("cmp1_busy", bc, 18);
    check("cmp1_we", wc, 0);

    // start pulsed (with reserved op) mid-FILL must be ignored.
    v = '{2'b00, 8'h00, 8'h20, 9'd8, 8'h55, 8'h00, 1'b0, 9, 8, 1, 0, 8'hFF};
    run_cmd(v, 3, bc, wc, dc, fw, lw);
    check("poke_busy", bc, 9);
    check("poke_we", wc, 8);
    check("poke_done", dc, 1);
    check("poke_err", err, 0);
    check("poke_ram_27", mem[8'h27], 8'h55);

    // Reset in the middle of a 16-word COPY 10->90.
    @(negedge clk);
    op = 2'b01; src_addr = 8'h10; dst_addr = 8'h90; length = 9'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wc = 0;
    for (int cyc = 1; cyc < 40 && wc < 5; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (port_c_we) wc++;
    end
    check("midrst_we_seen", wc, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_we_drop", port_c_we, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("midrst_no_done", dc, 0);
    check("midrst_ram_93", mem[8'h93], 8'hEC);
    check("midrst_ram_94", mem[8'h94], 8'h6B);
    check("midrst_ram_9f", mem[8'h9F], 8'h60);
    check("midrst_first", first_mismatch, 8'hFF);

    v = '{2'b01, 8'h10, 8'h90, 9'd16, 8'h00, 8'h00, 1'b0, 18, 16, 2, 0, 8'hFF};
    run_cmd(v, -1, bc, wc, dc, fw, lw);
    check("rerun_busy", bc, 18);
    check("rerun_we", wc, 16);
    check("rerun_done", dc, 1);
    check("rerun_ram_94", mem[8'h94], 8'hEB);
    check("rerun_ram_9f", mem[8'h9F], 8'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
